// File: rtl/cod_pri.sv
// Generic MSB-first priority encoder with enable: y/gs are combinational (zero latency),
// y_q/gs_q are the same result registered one clk later; no backpressure, accepts every cycle.
module cod_pri #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i,
    input  logic         en,
    output logic [W-1:0] y,
    output logic         gs,
    output logic [W-1:0] y_q,
    output logic         gs_q
);

    logic [W-1:0] w_y;
    logic         w_gs;
    logic [W-1:0] r_y_q;
    logic         r_gs_q;

    // Ascending scan: a higher set bit overwrites any lower one, so the MSB wins
    // and unknowns on lower bits never reach y once a higher bit is set.
    always_comb begin
        w_y  = '0;
        w_gs = en & (|i);
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (i[k]) begin
                    w_y = W'(k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q  <= '0;
            r_gs_q <= 1'b0;
        end else begin
            r_y_q  <= w_y;
            r_gs_q <= w_gs;
        end
    end

    assign y    = w_y;
    assign gs   = w_gs;
    assign y_q  = r_y_q;
    assign gs_q = r_gs_q;

endmodule

// File: tb/tb_cod_pri.sv
// Self-checking bench for cod_pri at N=4 and N=8 against an arithmetic reference model.
module tb_cod_pri;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i4;
    logic       en;
    logic [1:0] y4, y4_q;
    logic       gs4, gs4_q;
    logic [7:0] i8;
    logic [2:0] y8, y8_q;
    logic       gs8, gs8_q;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cod_pri #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .i(i4), .en(en),
        .y(y4), .gs(gs4), .y_q(y4_q), .gs_q(gs4_q)
    );

    cod_pri #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .i(i8), .en(en),
        .y(y8), .gs(gs8), .y_q(y8_q), .gs_q(gs8_q)
    );

    // floor(log2(v)) by repeated halving; 0 for v==0 or when disabled
    function automatic int ref_idx(input logic [63:0] v, input logic e);
        int idx = 0;
        if (!e) return 0;
        while (v > 1) begin
            v = v >> 1;
            idx++;
        end
        return idx;
    endfunction

    function automatic logic ref_gs(input logic [63:0] v, input logic e);
        return e && (v != 0);
    endfunction

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; i4 = 4'h0; i8 = 8'h0;
        edge_settle();
        tests_run++;
        if (y4_q !== 2'd0 || gs4_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_n4: y_q=%0d gs_q=%0b expected 0/0", y4_q, gs4_q);
        end
        tests_run++;
        if (y8_q !== 3'd0 || gs8_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_n8: y_q=%0d gs_q=%0b expected 0/0", y8_q, gs8_q);
        end
        rst = 1'b0;
    endtask

    task automatic test_comb_sweep();
        int exp_y [16] = '{0,0,1,1,2,2,2,2,3,3,3,3,3,3,3,3};
        en = 1'b1;
        for (int v = 0; v < 16; v++) begin
            i4 = v[3:0];
            #1;
            tests_run++;
            if (y4 !== exp_y[v][1:0] || gs4 !== (v != 0)) begin
                tests_failed++;
                $display("FAIL comb_sweep i=%b: y=%0d gs=%0b expected %0d/%0b",
                         i4, y4, gs4, exp_y[v], (v != 0));
            end
        end
    endtask

    task automatic test_enable_off();
        en = 1'b0;
        for (int v = 0; v < 16; v++) begin
            i4 = v[3:0];
            #1;
            tests_run++;
            if (y4 !== 2'd0 || gs4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL enable_off i=%b: y=%0d gs=%0b expected 0/0", i4, y4, gs4);
            end
        end
    endtask

    task automatic test_registered();
        edge_settle();
        i4 = 4'b0100; en = 1'b1;
        #1;
        tests_run++;
        if (y4 !== 2'd2 || gs4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reg_comb: y=%0d gs=%0b expected 2/1", y4, gs4);
        end
        edge_settle();
        tests_run++;
        if (y4_q !== 2'd2 || gs4_q !== 1'b1) begin
            tests_failed++;
            $display("FAIL reg_q_0100: y_q=%0d gs_q=%0b expected 2/1", y4_q, gs4_q);
        end
        i4 = 4'b1001;
        edge_settle();
        tests_run++;
        if (y4_q !== 2'd3 || gs4_q !== 1'b1) begin
            tests_failed++;
            $display("FAIL reg_q_1001: y_q=%0d gs_q=%0b expected 3/1", y4_q, gs4_q);
        end
    endtask

    task automatic test_reset_midstream();
        i4 = 4'b1000; en = 1'b1; rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            edge_settle();
            tests_run++;
            if (y4_q !== 2'd0 || gs4_q !== 1'b0 || y4 !== 2'd3 || gs4 !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_hold edge%0d: y_q=%0d gs_q=%0b y=%0d gs=%0b expected 0/0/3/1",
                         k, y4_q, gs4_q, y4, gs4);
            end
        end
        rst = 1'b0;
        edge_settle();
        tests_run++;
        if (y4_q !== 2'd3 || gs4_q !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: y_q=%0d gs_q=%0b expected 3/1", y4_q, gs4_q);
        end
    endtask

    task automatic test_en_toggle();
        i4 = 4'b1111; en = 1'b1;
        edge_settle();
        en = 1'b0;
        #1;
        tests_run++;
        if (y4 !== 2'd0 || gs4 !== 1'b0 || y4_q !== 2'd3 || gs4_q !== 1'b1) begin
            tests_failed++;
            $display("FAIL en_drop_comb: y=%0d gs=%0b y_q=%0d gs_q=%0b expected 0/0/3/1",
                     y4, gs4, y4_q, gs4_q);
        end
        edge_settle();
        tests_run++;
        if (y4_q !== 2'd0 || gs4_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_drop_reg: y_q=%0d gs_q=%0b expected 0/0", y4_q, gs4_q);
        end
    endtask

    task automatic test_param_n8();
        logic [7:0] pat [3] = '{8'h81, 8'h01, 8'h00};
        int         ey  [3] = '{7, 0, 0};
        logic       eg  [3] = '{1'b1, 1'b1, 1'b0};
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i8 = pat[k];
            #1;
            tests_run++;
            if (y8 !== ey[k][2:0] || gs8 !== eg[k]) begin
                tests_failed++;
                $display("FAIL param_n8 i=%h: y=%0d gs=%0b expected %0d/%0b",
                         i8, y8, gs8, ey[k], eg[k]);
            end
        end
    endtask

    task automatic test_random();
        int   e4, e8;
        logic g4, g8;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            // i/en/rst still hold the values sampled at this edge
            e4 = rst ? 0 : ref_idx({60'd0, i4}, en);
            g4 = rst ? 1'b0 : ref_gs({60'd0, i4}, en);
            e8 = rst ? 0 : ref_idx({56'd0, i8}, en);
            g8 = rst ? 1'b0 : ref_gs({56'd0, i8}, en);
            tests_run++;
            if (y4_q !== e4[1:0] || gs4_q !== g4 || y8_q !== e8[2:0] || gs8_q !== g8) begin
                tests_failed++;
                $display("FAIL random_reg n=%0d: n4 %0d/%0b n8 %0d/%0b expected n4 %0d/%0b n8 %0d/%0b",
                         n, y4_q, gs4_q, y8_q, gs8_q, e4, g4, e8, g8);
            end
            i4  = 4'($urandom);
            i8  = 8'($urandom) >> $urandom_range(0, 7);
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 15) == 0);
            #1;
            e4 = ref_idx({60'd0, i4}, en);
            e8 = ref_idx({56'd0, i8}, en);
            tests_run++;
            if (y4 !== e4[1:0] || gs4 !== ref_gs({60'd0, i4}, en) ||
                y8 !== e8[2:0] || gs8 !== ref_gs({56'd0, i8}, en)) begin
                tests_failed++;
                $display("FAIL random_comb n=%0d i4=%b i8=%b en=%b: y4=%0d gs4=%0b y8=%0d gs8=%0b expected y4=%0d y8=%0d",
                         n, i4, i8, en, y4, gs4, y8, gs8, e4, e8);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb_sweep();
        test_enable_off();
        test_registered();
        test_reset_midstream();
        test_en_toggle();
        test_param_n8();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
